// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue
//   Instruction fetch stage feeding pre-decode. Reads words at a sequential
//   PC, one outstanding read at a time. Each returned word is buffered with
//   its PC in a DEPTH-entry FIFO. Records are handed downstream one at a time
//   on o_data, and a tag increment marks each new record. A redirect flushes
//   the FIFO and drops any read still in flight.
//
// Ports
//   i_clock, i_reset      rising-edge clock, synchronous active-high reset
//   o_bus_request         read request, held until i_bus_ready
//   o_bus_address         word address of the current request
//   i_bus_ready           read completes this cycle, i_bus_rdata valid
//   i_bus_rdata           returned instruction word
//   i_jump, i_jump_pc     redirect pulse and target
//   i_stall               downstream refuses a new record this cycle
//   o_data                current record (tag, pc, instruction)
//
// state    | meaning
// IDLE     | no read outstanding; issue one when the FIFO has space
// REQUEST  | read outstanding; returned word will be pushed
// DISCARD  | read outstanding but redirected; returned word is dropped

package cpu_fetch_pkg;
    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        access_fault;
    } fetch_data_t;
endpackage

module cpu_fetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_jump,
    input  logic [31:0] i_jump_pc,
    input  logic        i_stall,
    output fetch_data_t o_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_data_t data_q, data_d;

    logic [31:0] mem_pc_q    [DEPTH];
    logic [31:0] mem_instr_q [DEPTH];

    logic push;
    logic pop;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        push    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!i_jump && (count_q < CW'(DEPTH))) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (i_bus_ready) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!i_jump) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end else if (i_jump) begin
                    // Bus still owes us a word for the old address; keep the
                    // request stable and swallow the reply later.
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (i_bus_ready) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (i_jump) begin
            pc_d = i_jump_pc & 32'hFFFF_FFFC;
        end
    end

    // Flush wins over push and pop, so a redirect never emits a stale record.
    assign pop = !i_stall && (count_q != '0) && !i_jump;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;

        if (i_jump) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (pop) begin
            data_d.tag         = data_q.tag + 8'd1;
            data_d.pc          = mem_pc_q[rd_ptr_q];
            data_d.instruction = mem_instr_q[rd_ptr_q];
            data_d.access_fault = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= 32'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end

    // Storage needs no reset; count gates every read of it.
    always_ff @(posedge i_clock) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= pc_q;
            mem_instr_q[wr_ptr_q] <= i_bus_rdata;
        end
    end

    assign o_bus_request = req_q;
    assign o_bus_address = addr_q;
    assign o_data        = data_q;

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Directed bench for cpu_fetch_queue (DEPTH=4, RESET_PC=0).
// Bus words are 32'hC0DE_0000 + address so every record is predictable.
module tb_cpu_fetch_queue;
    import cpu_fetch_pkg::*;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        o_bus_request;
    logic        i_bus_ready;
    logic [31:0] o_bus_address;
    logic [31:0] i_bus_rdata;
    logic        i_jump;
    logic [31:0] i_jump_pc;
    logic        i_stall;
    fetch_data_t o_data;

    int       checks = 0;
    int       errors = 0;
    int       reads  = 0;
    bit       auto_ready = 1'b0;
    bit       saw_zero;
    logic [7:0] prev_tag;

    cpu_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .o_bus_request (o_bus_request),
        .i_bus_ready   (i_bus_ready),
        .o_bus_address (o_bus_address),
        .i_bus_rdata   (i_bus_rdata),
        .i_jump        (i_jump),
        .i_jump_pc     (i_jump_pc),
        .i_stall       (i_stall),
        .o_data        (o_data)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string name, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock; inputs change 1 time unit after the rising edge.
    task automatic cyc();
        if (i_bus_ready && o_bus_request && !i_reset) reads++;
        @(posedge i_clock);
        #1;
        if (auto_ready) begin
            i_bus_ready = o_bus_request;
            i_bus_rdata = 32'hC0DE_0000 + o_bus_address;
        end
    endtask

    task automatic do_reset();
        i_reset     = 1'b1;
        i_jump      = 1'b0;
        i_bus_ready = 1'b0;
        cyc();
        cyc();
        i_reset  = 1'b0;
        prev_tag = 8'd0;
        reads    = 0;
    endtask

    task automatic serve(input logic [31:0] word);
        i_bus_ready = 1'b1;
        i_bus_rdata = word;
        cyc();
        i_bus_ready = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!o_bus_request && n < 40) begin
            cyc();
            n++;
        end
        chk({name, "_req_timeout"}, 96'(n < 40), 96'd1);
    endtask

    task automatic check_record(input string name, input logic [7:0] etag, input logic [31:0] epc);
        chk({name, "_tag"}, 96'(o_data.tag), 96'(etag));
        chk({name, "_pc"}, 96'(o_data.pc), 96'(epc));
        chk({name, "_instr"}, 96'(o_data.instruction), 96'(32'hC0DE_0000 + epc));
        prev_tag = o_data.tag;
    endtask

    task automatic wait_record(input string name, input logic [7:0] etag, input logic [31:0] epc);
        int n = 0;
        while (o_data.tag == prev_tag && n < 40) begin
            cyc();
            n++;
        end
        chk({name, "_rec_timeout"}, 96'(n < 40), 96'd1);
        check_record(name, etag, epc);
    endtask

    initial begin
        i_reset     = 1'b1;
        i_bus_ready = 1'b0;
        i_bus_rdata = 32'd0;
        i_jump      = 1'b0;
        i_jump_pc   = 32'd0;
        i_stall     = 1'b0;

        // Reset values, then streaming with an always-ready bus.
        auto_ready = 1'b1;
        do_reset();
        chk("rst_req", 96'(o_bus_request), 96'd0);
        chk("rst_addr", 96'(o_bus_address), 96'd0);
        chk("rst_odata", 96'(o_data), 96'd0);
        cyc();
        chk("s1_req0", 96'(o_bus_request), 96'd1);
        chk("s1_addr0", 96'(o_bus_address), 96'h0);
        wait_record("s1_r1", 8'd1, 32'h0);
        chk("s1_addr4", 96'(o_bus_address), 96'h4);
        wait_record("s1_r2", 8'd2, 32'h4);
        chk("s1_addr8", 96'(o_bus_address), 96'h8);
        wait_record("s1_r3", 8'd3, 32'h8);

        // Stall: the FIFO fills with exactly DEPTH words and fetching stops.
        i_stall = 1'b1;
        do_reset();
        repeat (20) cyc();
        chk("s2_reads", 96'(reads), 96'd4);
        chk("s2_req_off", 96'(o_bus_request), 96'd0);
        chk("s2_tag_hold", 96'(o_data.tag), 96'd0);
        i_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_record("s2_burst", 8'(i + 1), 32'(4 * i));
        end
        wait_record("s2_resume", 8'd5, 32'h10);

        // Redirect while the read of 0x8 is pending; reply arrives later.
        auto_ready = 1'b0;
        do_reset();
        wait_req("s3_a");
        serve(32'hC0DE_0000);
        wait_req("s3_b");
        serve(32'hC0DE_0004);
        wait_req("s3_c");
        chk("s3_addr8", 96'(o_bus_address), 96'h8);
        chk("s3_tag2", 96'(o_data.tag), 96'd2);
        prev_tag    = o_data.tag;
        i_jump      = 1'b1;
        i_jump_pc   = 32'h0000_0103;
        cyc();
        i_jump = 1'b0;
        chk("s3_disc_req", 96'(o_bus_request), 96'd1);
        chk("s3_disc_addr", 96'(o_bus_address), 96'h8);
        cyc();
        cyc();
        serve(32'hC0DE_0008);
        chk("s3_drop_req", 96'(o_bus_request), 96'd0);
        cyc();
        chk("s3_new_req", 96'(o_bus_request), 96'd1);
        chk("s3_new_addr", 96'(o_bus_address), 96'h100);
        serve(32'hC0DE_0100);
        chk("s3_tag_keep", 96'(o_data.tag), 96'd2);
        wait_record("s3_r100", 8'd3, 32'h100);

        // Redirect coinciding with bus ready and a pop request.
        i_stall = 1'b1;
        do_reset();
        wait_req("s4_a");
        serve(32'hC0DE_0000);
        wait_req("s4_b");
        chk("s4_addr4", 96'(o_bus_address), 96'h4);
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'hC0DE_0004;
        i_jump      = 1'b1;
        i_jump_pc   = 32'h0000_0100;
        i_stall     = 1'b0;
        cyc();
        i_bus_ready = 1'b0;
        i_jump      = 1'b0;
        chk("s4_odata_hold", 96'(o_data), 96'd0);
        chk("s4_req_drop", 96'(o_bus_request), 96'd0);
        cyc();
        chk("s4_addr100", 96'(o_bus_address), 96'h100);
        serve(32'hC0DE_0100);
        wait_record("s4_r100", 8'd1, 32'h100);

        // Long run: tag wraps through 0, pc advances by 4 each record.
        auto_ready = 1'b1;
        do_reset();
        saw_zero = 1'b0;
        for (int i = 0; i < 300; i++) begin
            wait_record("s5", 8'(i + 1), 32'(4 * i));
            if (o_data.tag == 8'd0) saw_zero = 1'b1;
        end
        chk("s5_wrap_zero", 96'(saw_zero), 96'd1);

        // Reset while a read is pending.
        auto_ready  = 1'b0;
        i_bus_ready = 1'b0;
        wait_req("s6_a");
        i_reset = 1'b1;
        cyc();
        chk("s6_req_off", 96'(o_bus_request), 96'd0);
        chk("s6_odata", 96'(o_data), 96'd0);
        i_reset  = 1'b0;
        prev_tag = 8'd0;
        cyc();
        chk("s6_req_on", 96'(o_bus_request), 96'd1);
        chk("s6_addr", 96'(o_bus_address), 96'h0);
        serve(32'hC0DE_0000);
        wait_record("s6_r0", 8'd1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
